// File: rtl/tea_pipe_scheduler.sv
// Grants a shared TEA pipeline to one requester at a time, streams its blocks,
// drains before every key change and tags each ciphertext with its requester id.
module tea_pipe_scheduler #(
    parameter int NREQ      = 4,
    parameter int PIPE_LAT  = 33,
    parameter int MAX_BURST = 16,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [64*NREQ-1:0]    req_data,
    input  logic [128*NREQ-1:0]   req_key,
    output logic [63:0]           pt_out,
    output logic [127:0]          key_out,
    input  logic [63:0]           ct_in,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [63:0]           rsp_data
);
    localparam int TDEPTH = PIPE_LAT + 1;
    localparam int BW     = $clog2(MAX_BURST + 1);
    localparam int IFW    = $clog2(PIPE_LAT + 2);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
    localparam logic [IDW-1:0] OWNER_RST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    owner_q, owner_d, grant_s;
    logic [BW-1:0]     burst_q, burst_d;
    logic [IFW-1:0]    inflight_q, inflight_d;
    logic [63:0]       pt_q, pt_d;
    logic [127:0]      key_q, key_d;
    logic [TDEPTH-1:0] tag_v_q;
    logic [IDW-1:0]    tag_id_q [TDEPTH];
    logic [63:0]       data_arr_s [NREQ];
    logic [127:0]      key_arr_s [NREQ];
    logic [NREQ-1:0]   owner_oh_s;
    logic              any_valid_s, other_valid_s, issue_s, retire_s, burst_full_s;

    // Round-robin: the candidate closest after 'last' wins, so scan farthest first.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] last);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] cand;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (v[cand]) begin
                pick = cand;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Unpack the flat requester buses into per-requester views.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr_s[i] = req_data[64*i +: 64];
            key_arr_s[i]  = req_key[128*i +: 128];
        end
    end

    assign owner_oh_s    = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    assign any_valid_s   = |req_valid;
    assign other_valid_s = |(req_valid & ~owner_oh_s);
    assign burst_full_s  = (burst_q == BURST_MAX);
    assign issue_s       = |(req_valid & req_ready);
    assign retire_s      = tag_v_q[TDEPTH-1];
    assign grant_s       = rr_pick(req_valid, owner_q);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant/datapath next values.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        burst_d = burst_q;
        key_d   = key_q;
        pt_d    = pt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    owner_d = grant_s;
                    key_d   = key_arr_s[grant_s];
                    burst_d = {BW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    pt_d    = data_arr_s[owner_q];
                    burst_d = burst_q + BW'(1);
                end else begin
                    pt_d    = pt_q;
                end
                if (other_valid_s && (!req_valid[owner_q] || burst_full_s)) begin
                    state_d = ST_DRAIN;
                end else if (burst_full_s) begin
                    burst_d = {BW{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q != {IFW{1'b0}}) begin
                    state_d = ST_DRAIN;
                end else if (any_valid_s) begin
                    owner_d = grant_s;
                    key_d   = key_arr_s[grant_s];
                    burst_d = {BW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready goes only to the owner, and only while its burst has room.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (state_q == ST_RUN && !burst_full_s) begin
            req_ready[owner_q] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // In-flight count: a simultaneous issue and retire cancel out.
    always_comb begin
        case ({issue_s, retire_s})
            2'b10:   inflight_d = inflight_q + IFW'(1);
            2'b01:   inflight_d = inflight_q - IFW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Grant and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWNER_RST;
            burst_q    <= {BW{1'b0}};
            inflight_q <= {IFW{1'b0}};
            pt_q       <= 64'd0;
            key_q      <= 128'd0;
        end else begin
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            inflight_q <= inflight_d;
            pt_q       <= pt_d;
            key_q      <= key_d;
        end
    end

    // Tag line travels alongside the pipeline, one entry per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= {TDEPTH{1'b0}};
            for (int i = 0; i < TDEPTH; i++) begin
                tag_id_q[i] <= {IDW{1'b0}};
            end
        end else begin
            tag_v_q     <= {tag_v_q[TDEPTH-2:0], issue_s};
            tag_id_q[0] <= issue_s ? owner_q : {IDW{1'b0}};
            for (int i = 1; i < TDEPTH; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // Response capture when a valid tag reaches the end of the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= {IDW{1'b0}};
            rsp_data  <= 64'd0;
        end else if (retire_s) begin
            rsp_valid <= 1'b1;
            rsp_id    <= tag_id_q[TDEPTH-1];
            rsp_data  <= ct_in;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

    assign pt_out  = pt_q;
    assign key_out = key_q;
endmodule

// File: tb/tb_tea_pipe_scheduler.sv
// Bench for tea_pipe_scheduler: a round-per-stage TEA pipeline stand-in plus a
// scoreboard that predicts every response from plain TEA and issue timing.
module tb_tea_pipe_scheduler;
    localparam int NREQ = 4;
    localparam int PIPE_LAT = 33;
    localparam int MAX_BURST = 16;
    localparam int IDW = 2;
    localparam int RSP_LAT = PIPE_LAT + 1;
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [64*NREQ-1:0]   req_data;
    logic [128*NREQ-1:0]  req_key;
    logic [63:0]          pt_out;
    logic [127:0]         key_out;
    logic [63:0]          ct_in;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [63:0]          rsp_data;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int kchg = 0;
    logic [127:0] prev_key = 128'd0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    ct;
        int             cyc;
    } exp_t;
    exp_t expq[$];
    exp_t e_mon;
    int log_id[$];
    int log_cyc[$];

    typedef struct {
        int           id;
        logic [127:0] key;
        logic [63:0]  pt;
        logic [63:0]  ct;
    } vec_t;
    vec_t vecs[8];

    tea_pipe_scheduler #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key), .pt_out(pt_out), .key_out(key_out),
        .ct_in(ct_in), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tea_ref(input logic [63:0] pt, input logic [127:0] k);
        logic [31:0] v0, v1, sum;
        v0 = pt[63:32]; v1 = pt[31:0]; sum = 32'd0;
        for (int r = 0; r < 32; r++) begin
            sum = sum + DELTA;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] tea_round(input logic [63:0] v, input logic [127:0] k, input int r);
        logic [31:0] v0, v1, sum;
        v0 = v[63:32]; v1 = v[31:0]; sum = 32'(r) * DELTA;
        v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
        v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
        return {v0, v1};
    endfunction

    // Pipeline stand-in: every stage uses the live key, so a key change mid-flight corrupts results.
    logic [63:0] stg [PIPE_LAT];
    assign ct_in = stg[PIPE_LAT-1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) stg[i] <= 64'd0;
        end else begin
            stg[0] <= tea_round(pt_out, key_out, 1);
            for (int i = 1; i < PIPE_LAT - 1; i++) stg[i] <= tea_round(stg[i-1], key_out, i + 1);
            stg[PIPE_LAT-1] <= stg[PIPE_LAT-2];
        end
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard and invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            prev_key = key_out;
        end else begin
            if (key_out !== prev_key) begin
                kchg++;
                checks++;
                if (expq.size() != 0) begin
                    failures++;
                    $display("FAIL key_stable: key_out changed with %0d blocks outstanding (required 0)", expq.size());
                end
                prev_key = key_out;
            end
            while (expq.size() > 0 && expq[0].cyc < cyc_cnt) begin
                checks++; failures++;
                $display("FAIL rsp_missing: no response at cycle %0d for id %0d", expq[0].cyc, expq[0].id);
                void'(expq.pop_front());
            end
            if (rsp_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected: id=%0d data=%h with nothing outstanding", rsp_id, rsp_data);
                end else begin
                    e_mon = expq.pop_front();
                    if (e_mon.cyc != cyc_cnt || e_mon.id !== rsp_id || e_mon.ct !== rsp_data) begin
                        failures++;
                        $display("FAIL rsp_check: actual cyc=%0d id=%0d data=%h required cyc=%0d id=%0d data=%h",
                                 cyc_cnt, rsp_id, rsp_data, e_mon.cyc, e_mon.id, e_mon.ct);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e_mon.id  = IDW'(i);
                    e_mon.ct  = tea_ref(req_data[64*i +: 64], req_key[128*i +: 128]);
                    e_mon.cyc = cyc_cnt + 1 + RSP_LAT;
                    expq.push_back(e_mon);
                    log_id.push_back(i);
                    log_cyc.push_back(cyc_cnt + 1);
                end
            end
            if (req_ready != '0) begin
                checks++;
                if ($countones(req_ready) > 1) begin
                    failures++;
                    $display("FAIL ready_onehot: actual req_ready=%b required at most one bit", req_ready);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        log_id.delete();
        log_cyc.delete();
        kchg = 0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && expq.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk_int("drain_empty", expq.size(), 0);
    endtask

    task automatic stream(input logic [NREQ-1:0] en, input int n, input int gap_id,
                          input int gap_after, input int gap_len);
        int rem [NREQ];
        int issued [NREQ];
        int gap_left;
        logic [NREQ-1:0] hs;
        bit done;
        gap_left = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = en[i] ? n : 0;
            issued[i] = 0;
            req_data[64*i +: 64] = {$urandom, $urandom};
        end
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            for (int i = 0; i < NREQ; i++)
                req_valid[i] = (rem[i] > 0) && !(i == gap_id && gap_left > 0);
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            if (gap_left > 0) gap_left--;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    rem[i]--;
                    issued[i]++;
                    req_data[64*i +: 64] = {$urandom, $urandom};
                    if (i == gap_id && issued[i] == gap_after) gap_left = gap_len;
                end
            end
            done = 1'b1;
            for (int i = 0; i < NREQ; i++) if (rem[i] != 0) done = 1'b0;
        end
        req_valid = '0;
        chk_int("stream_done", int'(done), 1);
    endtask

    initial begin : main
        bit got;
        int lat;
        int ok;
        int cnt;
        logic [127:0] k2;
        logic [NREQ-1:0] hs;

        rst_n = 1'b0; req_valid = '0; req_data = '0; req_key = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_pt_out", 128'(pt_out), 128'd0);
        chk("rst_key_out", key_out, 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_id", 128'(rsp_id), 128'd0);
        chk("rst_rsp_data", 128'(rsp_data), 128'd0);
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        @(negedge clk) rst_n = 1'b1;

        // Known answer plus first issue from IDLE.
        @(posedge clk); #1;
        req_key[127:0] = 128'd0; req_data[63:0] = 64'd0; req_valid[0] = 1'b1;
        @(negedge clk);
        chk("idle_ready_low", 128'(req_ready), 128'd0);
        @(negedge clk);
        chk("first_ready", 128'(req_ready), 128'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 0; got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        chk_int("kat_latency", lat, RSP_LAT);
        chk("kat_id", 128'(rsp_id), 128'd0);
        chk("kat_data", 128'(rsp_data), 128'h41EA3A0A94BAA940);
        @(posedge clk); #1;
        chk("kat_pulse_width", 128'(rsp_valid), 128'd0);

        // Single-block vectors across requesters.
        vecs[0] = '{id: 0, key: 128'd0, pt: 64'd0, ct: 64'h41EA3A0A94BAA940};
        vecs[1] = '{id: 1, key: {$urandom, $urandom, $urandom, $urandom}, pt: 64'hFFFFFFFFFFFFFFFF, ct: 64'd0};
        vecs[2] = '{id: 2, key: {128{1'b1}}, pt: 64'h0123456789ABCDEF, ct: 64'd0};
        vecs[3] = '{id: 3, key: {$urandom, $urandom, $urandom, $urandom}, pt: {$urandom, $urandom}, ct: 64'd0};
        vecs[4] = '{id: 0, key: {$urandom, $urandom, $urandom, $urandom}, pt: 64'd1, ct: 64'd0};
        vecs[5] = '{id: 2, key: {$urandom, $urandom, $urandom, $urandom}, pt: {$urandom, $urandom}, ct: 64'd0};
        vecs[6] = '{id: 1, key: 128'h000102030405060708090A0B0C0D0E0F, pt: 64'h8000000000000000, ct: 64'd0};
        vecs[7] = '{id: 3, key: {$urandom, $urandom, $urandom, $urandom}, pt: {$urandom, $urandom}, ct: 64'd0};
        for (int v = 1; v < 8; v++) vecs[v].ct = tea_ref(vecs[v].pt, vecs[v].key);

        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            req_key[128*vecs[v].id +: 128] = vecs[v].key;
            req_data[64*vecs[v].id +: 64] = vecs[v].pt;
            req_valid[vecs[v].id] = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (req_ready[vecs[v].id]) got = 1'b1;
            end
            chk_int("vec_handshake", int'(got), 1);
            @(posedge clk); #1;
            req_valid = '0;
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (rsp_valid) got = 1'b1;
            end
            chk_int("vec_rsp_seen", int'(got), 1);
            chk("vec_rsp_id", 128'(rsp_id), 128'(vecs[v].id));
            chk("vec_rsp_data", 128'(rsp_data), 128'(vecs[v].ct));
        end
        wait_drain();

        // Full burst from requester 1.
        do_reset();
        req_key[128*1 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        stream(4'b0010, MAX_BURST, -1, 0, 0);
        wait_drain();
        chk_int("burst_count", log_id.size(), MAX_BURST);
        if (log_cyc.size() == MAX_BURST) chk_int("burst_span", log_cyc[MAX_BURST-1] - log_cyc[0], MAX_BURST - 1);

        // Contention between requesters 0 and 2.
        do_reset();
        req_key[128*0 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom} ^ 128'h1;
        if (k2 == req_key[127:0]) k2 = ~k2;
        req_key[128*2 +: 128] = k2;
        stream(4'b0101, MAX_BURST, -1, 0, 0);
        wait_drain();
        chk_int("cont_count", log_id.size(), 2 * MAX_BURST);
        ok = 1;
        if (log_id.size() == 2 * MAX_BURST) begin
            for (int j = 0; j < MAX_BURST; j++) if (log_id[j] != 0) ok = 0;
            for (int j = MAX_BURST; j < 2 * MAX_BURST; j++) if (log_id[j] != 2) ok = 0;
            chk_int("cont_order", ok, 1);
            chk_int("cont_switch_gap_ok", int'(log_cyc[MAX_BURST] - log_cyc[MAX_BURST-1] >= PIPE_LAT + 2), 1);
        end
        chk("cont_final_key", key_out, k2);
        chk_int("cont_key_loads", kchg, 2);

        // Owner idles, no contention: burst wraps without a drain.
        do_reset();
        req_key[128*3 +: 128] = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        stream(4'b1000, 20, 3, 6, 5);
        wait_drain();
        chk_int("wrap_count", log_id.size(), 20);
        if (log_cyc.size() == 20) chk_int("wrap_span", log_cyc[19] - log_cyc[0], 25);
        chk_int("wrap_key_loads", kchg, 1);

        // Reset with ten blocks in flight.
        do_reset();
        req_key[128*2 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        req_valid[2] = 1'b1;
        for (int k = 0; k < 100 && log_id.size() < 10; k++) begin
            @(posedge clk); #1;
            req_data[64*2 +: 64] = {$urandom, $urandom};
        end
        chk_int("rstmid_issued", log_id.size(), 10);
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("rstmid_pt_out", 128'(pt_out), 128'd0);
        chk("rstmid_key_out", key_out, 128'd0);
        chk("rstmid_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rstmid_rsp_id", 128'(rsp_id), 128'd0);
        chk("rstmid_rsp_data", 128'(rsp_data), 128'd0);
        chk("rstmid_req_ready", 128'(req_ready), 128'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk_int("rstmid_no_rsp", cnt, 0);

        // Randomized traffic from all requesters.
        do_reset();
        for (int i = 0; i < NREQ; i++) req_key[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[64*i +: 64] = {$urandom, $urandom};
                    end
                end else if (hs[i]) begin
                    req_data[64*i +: 64] = {$urandom, $urandom};
                    if ($urandom_range(3) == 0) req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        wait_drain();
        chk_int("rand_issued_nonzero", int'(log_id.size() > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
